// File: rtl/therm18_encode_gama.sv
// Thermometer-code (18 bit, filled from bit 17 down) to level encoder with bubble correction.
// Latency: 2 cycles (input register stage + output register stage).
// Backpressure: both stages advance only when the output is empty or being taken; in_ready = that enable.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   in_valid/in_ready/in_data  input handshake and 18-bit thermometer word
//   out_valid/out_ready        output handshake
//   out_code                   decoded level 0..18 (popcount, so bubbles are corrected)
//   out_err                    result came from a malformed word
//   clr_err                    one-cycle clear of err_cnt / err_sticky
//   err_cnt, err_sticky        saturating count / sticky flag of delivered error results
module therm18_encode_gama #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [17:0]          in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_code,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 err_sticky
);

  logic       en;
  logic [4:0] pc;
  logic       malformed;
  logic       s1_vld;
  logic [4:0] s1_code;
  logic       s1_err;
  logic       out_xfer;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign out_xfer = out_valid && out_ready;

  // The level is the number of ones regardless of shape; for a clean word this equals k.
  always_comb begin
    pc = '0;
    for (int i = 0; i < 18; i++) begin
      pc = pc + {4'd0, in_data[i]};
    end
  end

  // A clean code never has a one directly below a zero.
  assign malformed = |(in_data[16:0] & ~in_data[17:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_code   <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_err   <= 1'b0;
    end else if (en) begin
      s1_vld <= in_valid;
      // Input word is only captured on an actual transfer.
      if (in_valid) begin
        s1_code <= pc;
        s1_err  <= malformed;
      end
      out_valid <= s1_vld;
      out_code  <= s1_code;
      out_err   <= s1_err;
    end
  end

  // Clear wins over a same-cycle erroneous delivery; that delivery is not counted.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (out_xfer && out_err) begin
      if (!(&err_cnt)) begin
        err_cnt <= err_cnt + 1'b1;
      end
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_therm18_encode_gama.sv
module tb_therm18_encode_gama;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [17:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_code;
  logic        out_err;
  logic        clr_err;
  logic [7:0]  err_cnt;
  logic        err_sticky;

  logic        in_ready2, out_valid2, out_err2, err_sticky2;
  logic [4:0]  out_code2;
  logic [1:0]  err_cnt2;

  always #5 clk = ~clk;

  therm18_encode_gama dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
    .clr_err(clr_err), .err_cnt(err_cnt), .err_sticky(err_sticky)
  );

  therm18_encode_gama #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2), .out_err(out_err2),
    .clr_err(clr_err), .err_cnt(err_cnt2), .err_sticky(err_sticky2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] code;
    logic       err;
  } res_t;
  res_t q[$];

  int   m_cnt8 = 0;
  int   m_cnt2 = 0;
  logic m_sticky = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: level is the number of ones; word is clean iff it equals the k-ones prefix word.
  function automatic res_t ref_model(input logic [17:0] d);
    res_t r;
    int k;
    logic [17:0] clean;
    k = $countones(d);
    clean = 18'h3FFFF;
    clean = ~(clean >> k);
    r.code = 5'(k);
    r.err  = (d != clean);
    return r;
  endfunction

  function automatic logic [17:0] therm_word(input int k);
    logic [17:0] w;
    w = 18'h3FFFF;
    return ~(w >> k);
  endfunction

  // One clock: account for the transfers that happen at this edge, then check state after it.
  task automatic step();
    logic in_x, out_x, hold;
    logic [4:0] h_code;
    logic h_err;
    res_t e;
    #1;
    in_x  = in_valid && in_ready;
    out_x = out_valid && out_ready;
    hold  = out_valid && !out_ready && !rst;
    h_code = out_code;
    h_err  = out_err;
    if (!rst) chk("in_ready_vs_en", in_ready, !out_valid || out_ready);
    if (rst) begin
      q.delete();
      m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
    end else begin
      if (out_x) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
          e.code = 0; e.err = 0;
        end else begin
          e = q.pop_front();
          chk("out_code", out_code, e.code);
          chk("out_err", out_err, e.err);
          chk("out_code_w2", out_code2, e.code);
        end
      end
      if (clr_err) begin
        m_cnt8 = 0; m_cnt2 = 0; m_sticky = 1'b0;
      end else if (out_x && q.size() >= 0 && e.err) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
        m_sticky = 1'b1;
      end
      if (in_x) q.push_back(ref_model(in_data));
    end
    @(posedge clk);
    #1;
    chk("err_cnt", err_cnt, m_cnt8);
    chk("err_cnt_w2", err_cnt2, m_cnt2);
    chk("err_sticky", err_sticky, m_sticky);
    if (hold) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_code", out_code, h_code);
      chk("stall_err", out_err, h_err);
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    chk("drain_timeout", (q.size() != 0 || out_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [17:0] data;
    logic [4:0]  code;
    logic        err;
  } vec_t;

  initial begin
    vec_t tbl[11];
    int sent;
    int pat;
    tbl[0]  = '{18'h00000, 5'd0,  1'b0};
    tbl[1]  = '{18'h3FFFF, 5'd18, 1'b0};
    tbl[2]  = '{18'h20000, 5'd1,  1'b0};
    tbl[3]  = '{18'h3FFFE, 5'd17, 1'b0};
    tbl[4]  = '{18'h3FF00, 5'd10, 1'b0};
    tbl[5]  = '{18'h34000, 5'd3,  1'b1};
    tbl[6]  = '{18'h00001, 5'd1,  1'b1};
    tbl[7]  = '{18'h2AAAA, 5'd9,  1'b1};
    tbl[8]  = '{18'h1FFFF, 5'd17, 1'b1};
    tbl[9]  = '{18'h3FFFD, 5'd17, 1'b1};
    tbl[10] = '{18'h30001, 5'd3,  1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_sticky", err_sticky, 0);

    // Back-to-back sweep of clean words: first result two edges after first input, then one per cycle.
    out_ready = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      in_valid = 1'b1;
      in_data  = therm_word(k);
      step();
      if (k == 0) chk("sweep_latency_early", out_valid, 0);
      else begin
        chk("sweep_valid", out_valid, 1);
        chk("sweep_code", out_code, k - 1);
      end
    end
    in_valid = 1'b0;
    step();
    chk("sweep_last_valid", out_valid, 1);
    chk("sweep_last_code", out_code, 18);
    drain();

    // Single malformed word from a clean counter state.
    do_reset();
    in_valid = 1'b1; in_data = 18'b110100000000000000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("bubble_code", out_code, 3);
    chk("bubble_err", out_err, 1);
    drain();
    chk("bubble_err_cnt", err_cnt, 1);
    chk("bubble_sticky", err_sticky, 1);

    // Table of individual words.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = tbl[i].data; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("tbl_valid", out_valid, 1);
      chk("tbl_code", out_code, tbl[i].code);
      chk("tbl_err", out_err, tbl[i].err);
    end
    drain();

    // Five words with out_ready pattern 1,0,0 repeating.
    do_reset();
    sent = 0; pat = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      out_ready = (pat == 0);
      in_valid  = 1'b1;
      in_data   = therm_word(2 * sent + 1);
      #1;
      if (in_ready) sent++;
      step();
      pat = (pat + 1) % 3;
    end
    chk("stall_all_sent", sent, 5);
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      out_ready = (pat == 0);
      step();
      pat = (pat + 1) % 3;
    end
    drain();

    // Saturation of the narrow counter, then clear colliding with an erroneous delivery.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 18'h00001;
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("sat_cnt_w2", err_cnt2, 3);
    chk("sat_cnt_w8", err_cnt, 5);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 18'h2AAAA;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_hold_err", out_err, 1);
    out_ready = 1'b1; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_cnt_w2", err_cnt2, 0);
    chk("clr_cnt_w8", err_cnt, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_consumed", out_valid, 0);

    // Reset with two words in flight: neither may ever appear.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 18'h34000;
    step();
    in_data = 18'h3F000;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_err_cnt", err_cnt, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_no_output", out_valid, 0);
    end

    // All ones then all zeros.
    in_valid = 1'b1; in_data = 18'h3FFFF;
    step();
    in_data = 18'h00000;
    step();
    in_valid = 1'b0;
    chk("full_code", out_code, 18);
    chk("full_err", out_err, 0);
    step();
    chk("empty_code", out_code, 0);
    chk("empty_err", out_err, 0);
    drain();

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = ($urandom_range(0, 1) == 0) ? therm_word($urandom_range(0, 18)) : 18'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 24) == 0);
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
